lb_mst_arb: RTL and testbench
=============================

LB_MST_ARB -- requirements
Module: lb_mst_arb

Interface
REQ-001 Parameters SHALL be:
- LB_DATA_WDTH, default 32: data width.
- LB_ADDR_WDTH, default 32: address width.
- TOUT_CYC, default 255: ack timeout in cycles, range 1..65535.
- TOUT_RDATA, default 32'hDEAD_BEEF: read data returned on timeout.
REQ-002 Ports SHALL be:
- lb_clk, in, 1: single clock.
- lb_rst_n, in, 1: asynchronous, active-low reset.
- mN_wreq / mN_rreq, in, 1 each, N=0,1: master write/read request, one-cycle pulse.
- mN_waddr / mN_raddr, in, LB_ADDR_WDTH: address, valid with the request pulse.
- mN_wdata, in, LB_DATA_WDTH: write data, valid with mN_wreq.
- mN_wack / mN_rack, out, 1: completion pulse to master N.
- mN_rdata, out, LB_DATA_WDTH: read data, valid with mN_rack.
- lb_wreq / lb_rreq, out, 1: shared-bus request pulse.
- lb_waddr / lb_raddr, out, LB_ADDR_WDTH; lb_wdata, out, LB_DATA_WDTH: shared-bus address and data.
- lb_wack / lb_rack, in, 1; lb_rdata, in, LB_DATA_WDTH: shared-bus completion.
- tout_pulse, out, 1: one-cycle pulse on each timeout.
- tout_cnt, out, 16: saturating timeout count.
- ovf_flag, out, 1: sticky flag, set when a request is dropped.

Function
REQ-003 Each master SHALL have one write slot and one read slot that latch address and data on the request pulse; a slot is visible the next cycle.
REQ-004 A request arriving at an occupied slot SHALL be dropped (slot contents unchanged) and ovf_flag SHALL set.
REQ-005 The FSM SHALL have states IDLE, ISSUE and WAIT.
- IDLE -> ISSUE when any slot is occupied.
- ISSUE -> WAIT after exactly one cycle.
- WAIT -> IDLE on the matching ack or on timeout.
REQ-006 Arbitration in IDLE SHALL be round-robin between masters: the master not granted last wins when both are pending. After reset the priority pointer SHALL favour m0.
REQ-007 Within the granted master, a pending write SHALL be served before a pending read.
REQ-008 lb_wreq or lb_rreq SHALL be high only in ISSUE, for exactly one cycle. lb_*addr and lb_wdata SHALL be driven from the granted slot and held from ISSUE until the return to IDLE.
REQ-009 Latency: a request pulse at cycle T into an idle block with empty slots SHALL produce lb_*req at cycle T+2.
REQ-010 Acks SHALL be accepted in ISSUE or WAIT only, and only of the issued type (lb_wack for a write, lb_rack for a read). Any other ack SHALL be discarded.
REQ-011 An accepted ack at cycle M SHALL produce the granted master's mN_wack or mN_rack at M+1.
- For reads, mN_rdata SHALL equal lb_rdata captured at cycle M.
- The slot SHALL free at M+1.
- The FSM SHALL be in IDLE at M+1.
REQ-012 The timeout counter SHALL clear in ISSUE and increment each WAIT cycle.
REQ-013 When the counter equals TOUT_CYC without an ack, the block SHALL complete the transfer on the next cycle:
- mN_*ack asserted.
- mN_rdata = TOUT_RDATA for reads.
- tout_pulse high for 1 cycle.
- tout_cnt incremented, saturating at 16'hFFFF.
- return to IDLE.
REQ-014 An ack in the same cycle as the timeout condition SHALL win: normal completion, no tout_pulse.
REQ-015 mN_rdata SHALL hold its last value between acks. Ack outputs SHALL never be asserted for both masters in the same cycle.
REQ-016 A new request from a master in the same cycle its slot frees SHALL be latched, not dropped.

Reset
REQ-017 Asynchronous assertion of lb_rst_n low SHALL immediately clear:
- all slots, FSM (to IDLE), counter, priority pointer;
- all ack and req outputs, tout_pulse, tout_cnt, ovf_flag;
- mN_rdata and lb_* address/data outputs to 0.
REQ-018 Reset mid-transfer SHALL abandon the transfer with no master ack. A late lb_*ack after reset release SHALL be discarded per REQ-010.

Verification
REQ-019 m0_wreq, addr 0x10, data 0x55 at T; lb_wack at T+4 -> lb_wreq at T+2 with lb_waddr=0x10, lb_wdata=0x55; m0_wack at T+5.
REQ-020 m0_rreq (0x20) and m1_rreq (0x30) in the same cycle after reset -> m0 issued first and m1 second; m1_rdata = lb_rdata of the second ack.
REQ-021 TOUT_CYC=4, m1_rreq, no ack -> m1_rack with m1_rdata=0xDEADBEEF, tout_pulse=1, tout_cnt=1; a later stray lb_rack is ignored.
REQ-022 m0_wreq and m0_rreq pending together -> write issued before read; second m0_wreq while write slot is full -> dropped, ovf_flag=1.
REQ-023 lb_rst_n low during WAIT -> all outputs 0 immediately; after release, an lb_wack produces no master ack.
REQ-024 lb_rack at the exact cycle the counter equals TOUT_CYC -> normal rdata returned, tout_pulse stays 0.

Source files
------------

// File: rtl/lb_mst_arb_if.sv
// One local-bus link: write/read request pulses with address/data, and the ack/read-data return path.
interface lb_mst_arb_if #(
  parameter int LB_DATA_WDTH = 32,
  parameter int LB_ADDR_WDTH = 32
);
  logic                    wreq;
  logic [LB_ADDR_WDTH-1:0] waddr;
  logic [LB_DATA_WDTH-1:0] wdata;
  logic                    wack;
  logic                    rreq;
  logic [LB_ADDR_WDTH-1:0] raddr;
  logic                    rack;
  logic [LB_DATA_WDTH-1:0] rdata;

  modport master (output wreq, waddr, wdata, rreq, raddr, input wack, rack, rdata);
  modport slave  (input wreq, waddr, wdata, rreq, raddr, output wack, rack, rdata);
endinterface

// File: rtl/lb_mst_arb.sv
// Two-master local-bus arbiter: per-master write/read slots, round-robin grant,
// single outstanding transfer on the shared bus with an ack timeout.
module lb_mst_arb #(
  parameter int                      LB_DATA_WDTH = 32,
  parameter int                      LB_ADDR_WDTH = 32,
  parameter int                      TOUT_CYC     = 255,
  parameter logic [LB_DATA_WDTH-1:0] TOUT_RDATA   = LB_DATA_WDTH'(32'hDEAD_BEEF)
) (
  input  logic                lb_clk,
  input  logic                lb_rst_n,
  lb_mst_arb_if.slave         m0,
  lb_mst_arb_if.slave         m1,
  lb_mst_arb_if.master        lb,
  output logic                tout_pulse,
  output logic [15:0]         tout_cnt,
  output logic                ovf_flag
);
  // state   | meaning
  // S_IDLE  | no transfer; grant a pending slot
  // S_ISSUE | one-cycle lb_wreq/lb_rreq pulse, timeout counter cleared
  // S_WAIT  | waiting for the matching ack or the timeout
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [15:0] TOUT_LIM = 16'(TOUT_CYC);

  state_t state, state_nxt;

  logic [1:0]              req_w, req_r;
  logic [LB_ADDR_WDTH-1:0] req_waddr [2];
  logic [LB_ADDR_WDTH-1:0] req_raddr [2];
  logic [LB_DATA_WDTH-1:0] req_wdata [2];

  logic [1:0]              wslot_v, rslot_v;
  logic [LB_ADDR_WDTH-1:0] wslot_addr [2];
  logic [LB_ADDR_WDTH-1:0] rslot_addr [2];
  logic [LB_DATA_WDTH-1:0] wslot_data [2];

  logic                    prio, cur_mst, cur_wr;
  logic [15:0]             tcnt;
  logic [1:0]              pend;
  logic                    grant_sel, ack_ok, tout_hit, xfer_done;
  logic [1:0]              free_w, free_r, drop;

  logic [1:0]              mack_w, mack_r;
  logic [LB_DATA_WDTH-1:0] mrdata [2];
  logic [LB_ADDR_WDTH-1:0] bus_waddr, bus_raddr;
  logic [LB_DATA_WDTH-1:0] bus_wdata;

  assign req_w        = {m1.wreq, m0.wreq};
  assign req_r        = {m1.rreq, m0.rreq};
  assign req_waddr[0] = m0.waddr;
  assign req_waddr[1] = m1.waddr;
  assign req_raddr[0] = m0.raddr;
  assign req_raddr[1] = m1.raddr;
  assign req_wdata[0] = m0.wdata;
  assign req_wdata[1] = m1.wdata;

  assign pend      = wslot_v | rslot_v;
  assign grant_sel = (pend == 2'b11) ? prio : pend[1];
  assign ack_ok    = (state != S_IDLE) && (cur_wr ? lb.wack : lb.rack);
  // an ack in the timeout cycle takes precedence over the timeout
  assign tout_hit  = (state == S_WAIT) && !ack_ok && (tcnt == TOUT_LIM);
  assign xfer_done = ack_ok || tout_hit;

  assign free_w[0] = xfer_done &&  cur_wr && !cur_mst;
  assign free_w[1] = xfer_done &&  cur_wr &&  cur_mst;
  assign free_r[0] = xfer_done && !cur_wr && !cur_mst;
  assign free_r[1] = xfer_done && !cur_wr &&  cur_mst;
  assign drop[0]   = (req_w[0] && wslot_v[0] && !free_w[0]) || (req_r[0] && rslot_v[0] && !free_r[0]);
  assign drop[1]   = (req_w[1] && wslot_v[1] && !free_w[1]) || (req_r[1] && rslot_v[1] && !free_r[1]);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|pend) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = xfer_done ? S_IDLE : S_WAIT;
      S_WAIT:  if (xfer_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge lb_clk or negedge lb_rst_n) begin
    if (!lb_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // a slot being freed this cycle may be refilled by a request in the same cycle
  always_ff @(posedge lb_clk or negedge lb_rst_n) begin
    if (!lb_rst_n) begin
      wslot_v <= '0;
      rslot_v <= '0;
      for (int i = 0; i < 2; i++) begin
        wslot_addr[i] <= '0;
        rslot_addr[i] <= '0;
        wslot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_w[i] && (!wslot_v[i] || free_w[i])) begin
          wslot_v[i]    <= 1'b1;
          wslot_addr[i] <= req_waddr[i];
          wslot_data[i] <= req_wdata[i];
        end else if (free_w[i]) begin
          wslot_v[i] <= 1'b0;
        end
        if (req_r[i] && (!rslot_v[i] || free_r[i])) begin
          rslot_v[i]    <= 1'b1;
          rslot_addr[i] <= req_raddr[i];
        end else if (free_r[i]) begin
          rslot_v[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge lb_clk or negedge lb_rst_n) begin
    if (!lb_rst_n) begin
      prio      <= 1'b0;
      cur_mst   <= 1'b0;
      cur_wr    <= 1'b0;
      bus_waddr <= '0;
      bus_raddr <= '0;
      bus_wdata <= '0;
      tcnt      <= '0;
    end else begin
      if ((state == S_IDLE) && (|pend)) begin
        cur_mst <= grant_sel;
        cur_wr  <= wslot_v[grant_sel];
        prio    <= ~grant_sel;
        if (wslot_v[grant_sel]) begin
          bus_waddr <= wslot_addr[grant_sel];
          bus_wdata <= wslot_data[grant_sel];
        end else begin
          bus_raddr <= rslot_addr[grant_sel];
        end
      end
      if (state == S_ISSUE)     tcnt <= '0;
      else if (state == S_WAIT) tcnt <= tcnt + 16'd1;
    end
  end

  always_ff @(posedge lb_clk or negedge lb_rst_n) begin
    if (!lb_rst_n) begin
      mack_w     <= '0;
      mack_r     <= '0;
      mrdata[0]  <= '0;
      mrdata[1]  <= '0;
      tout_pulse <= 1'b0;
      tout_cnt   <= '0;
      ovf_flag   <= 1'b0;
    end else begin
      mack_w     <= free_w;
      mack_r     <= free_r;
      tout_pulse <= tout_hit;
      if (xfer_done && !cur_wr) mrdata[cur_mst] <= ack_ok ? lb.rdata : TOUT_RDATA;
      if (tout_hit && (tout_cnt != 16'hFFFF)) tout_cnt <= tout_cnt + 16'd1;
      if (|drop) ovf_flag <= 1'b1;
    end
  end

  assign m0.wack  = mack_w[0];
  assign m1.wack  = mack_w[1];
  assign m0.rack  = mack_r[0];
  assign m1.rack  = mack_r[1];
  assign m0.rdata = mrdata[0];
  assign m1.rdata = mrdata[1];

  assign lb.wreq  = (state == S_ISSUE) &&  cur_wr;
  assign lb.rreq  = (state == S_ISSUE) && !cur_wr;
  assign lb.waddr = bus_waddr;
  assign lb.wdata = bus_wdata;
  assign lb.raddr = bus_raddr;
endmodule

// File: tb/tb_lb_mst_arb.sv
// Bench for lb_mst_arb: directed scenarios plus a randomized run against a transaction-level model.
module tb_lb_mst_arb;
  localparam int          DW      = 32;
  localparam int          AW      = 32;
  localparam int          TOUT    = 4;
  localparam logic [31:0] TOUT_RD = 32'hDEAD_BEEF;

  logic        lb_clk = 1'b0;
  logic        lb_rst_n = 1'b0;
  logic        tout_pulse;
  logic [15:0] tout_cnt;
  logic        ovf_flag;
  int          n_tests = 0;
  int          n_fail = 0;

  lb_mst_arb_if #(.LB_DATA_WDTH(DW), .LB_ADDR_WDTH(AW)) m0_if ();
  lb_mst_arb_if #(.LB_DATA_WDTH(DW), .LB_ADDR_WDTH(AW)) m1_if ();
  lb_mst_arb_if #(.LB_DATA_WDTH(DW), .LB_ADDR_WDTH(AW)) bus_if ();

  lb_mst_arb #(
    .LB_DATA_WDTH(DW), .LB_ADDR_WDTH(AW), .TOUT_CYC(TOUT), .TOUT_RDATA(TOUT_RD)
  ) dut (
    .lb_clk(lb_clk), .lb_rst_n(lb_rst_n), .m0(m0_if), .m1(m1_if), .lb(bus_if),
    .tout_pulse(tout_pulse), .tout_cnt(tout_cnt), .ovf_flag(ovf_flag)
  );

  always #5 lb_clk = ~lb_clk;

  task automatic step();
    @(posedge lb_clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.wreq = 0; m0_if.rreq = 0; m0_if.waddr = '0; m0_if.raddr = '0; m0_if.wdata = '0;
    m1_if.wreq = 0; m1_if.rreq = 0; m1_if.waddr = '0; m1_if.raddr = '0; m1_if.wdata = '0;
    bus_if.wack = 0; bus_if.rack = 0; bus_if.rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    lb_rst_n = 1'b0;
    step(); step();
    lb_rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    lb_rst_n = 1'b0;
    #12;
    n_tests++;
    if ({m0_if.wack, m0_if.rack, m1_if.wack, m1_if.rack, bus_if.wreq, bus_if.rreq} !== 6'b0) begin
      n_fail++; $display("FAIL rst_strobes: got %b, expected 000000",
        {m0_if.wack, m0_if.rack, m1_if.wack, m1_if.rack, bus_if.wreq, bus_if.rreq});
    end
    n_tests++;
    if ({m0_if.rdata, m1_if.rdata, bus_if.waddr, bus_if.raddr, bus_if.wdata} !== '0) begin
      n_fail++; $display("FAIL rst_data: got %h %h %h %h %h, expected all 0",
        m0_if.rdata, m1_if.rdata, bus_if.waddr, bus_if.raddr, bus_if.wdata);
    end
    n_tests++;
    if ({tout_pulse, tout_cnt, ovf_flag} !== 18'b0) begin
      n_fail++; $display("FAIL rst_status: got tp=%b cnt=%0d ovf=%b, expected 0", tout_pulse, tout_cnt, ovf_flag);
    end
    lb_rst_n = 1'b1;
    repeat (3) begin
      step();
      n_tests++;
      if ({bus_if.wreq, bus_if.rreq} !== 2'b00) begin
        n_fail++; $display("FAIL rst_idle: got req=%b, expected 00", {bus_if.wreq, bus_if.rreq});
      end
    end
  endtask

  task automatic test_write();
    do_reset();
    m0_if.wreq = 1; m0_if.waddr = 32'h10; m0_if.wdata = 32'h55;
    step();                                   // T+1
    m0_if.wreq = 0;
    n_tests++;
    if (bus_if.wreq !== 1'b0) begin n_fail++; $display("FAIL wr_early: got %b, expected 0", bus_if.wreq); end
    step();                                   // T+2
    n_tests++;
    if ({bus_if.wreq, bus_if.rreq, bus_if.waddr, bus_if.wdata} !== {2'b10, 32'h10, 32'h55}) begin
      n_fail++; $display("FAIL wr_issue: got req=%b a=%h d=%h, expected 10 a=10 d=55",
        {bus_if.wreq, bus_if.rreq}, bus_if.waddr, bus_if.wdata);
    end
    step();                                   // T+3
    n_tests++;
    if ({bus_if.wreq, m0_if.wack} !== 2'b00) begin
      n_fail++; $display("FAIL wr_wait: got wreq/wack=%b, expected 00", {bus_if.wreq, m0_if.wack});
    end
    step();                                   // T+4: ack and a refill request together
    bus_if.wack = 1; m0_if.wreq = 1; m0_if.waddr = 32'h14; m0_if.wdata = 32'h66;
    step();                                   // T+5
    bus_if.wack = 0; m0_if.wreq = 0;
    n_tests++;
    if ({m0_if.wack, m1_if.wack, m0_if.rack} !== 3'b100) begin
      n_fail++; $display("FAIL wr_ack: got m0w/m1w/m0r=%b, expected 100", {m0_if.wack, m1_if.wack, m0_if.rack});
    end
    step();                                   // T+6
    n_tests++;
    if ({bus_if.wreq, bus_if.waddr, bus_if.wdata, ovf_flag, m0_if.wack} !== {1'b1, 32'h14, 32'h66, 2'b00}) begin
      n_fail++; $display("FAIL wr_refill: got wreq=%b a=%h d=%h ovf=%b wack=%b, expected 1 14 66 0 0",
        bus_if.wreq, bus_if.waddr, bus_if.wdata, ovf_flag, m0_if.wack);
    end
    bus_if.wack = 1;                          // ack during the issue cycle
    step();                                   // T+7
    bus_if.wack = 0;
    n_tests++;
    if (m0_if.wack !== 1'b1) begin n_fail++; $display("FAIL wr_issue_ack: got %b, expected 1", m0_if.wack); end
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_if.rreq = 1; m0_if.raddr = 32'h20;
    m1_if.rreq = 1; m1_if.raddr = 32'h30;
    step();                                   // T+1
    m0_if.rreq = 0; m1_if.rreq = 0;
    step();                                   // T+2
    n_tests++;
    if ({bus_if.rreq, bus_if.raddr} !== {1'b1, 32'h20}) begin
      n_fail++; $display("FAIL rr_first: got rreq=%b a=%h, expected 1 20", bus_if.rreq, bus_if.raddr);
    end
    step();                                   // T+3
    bus_if.rack = 1; bus_if.rdata = 32'hA1;
    step();                                   // T+4
    bus_if.rack = 0; bus_if.rdata = 32'h0;
    n_tests++;
    if ({m0_if.rack, m1_if.rack, m0_if.rdata} !== {2'b10, 32'hA1}) begin
      n_fail++; $display("FAIL rr_m0_ack: got m0r/m1r=%b rd=%h, expected 10 A1", {m0_if.rack, m1_if.rack}, m0_if.rdata);
    end
    step();                                   // T+5
    n_tests++;
    if ({bus_if.rreq, bus_if.raddr} !== {1'b1, 32'h30}) begin
      n_fail++; $display("FAIL rr_second: got rreq=%b a=%h, expected 1 30", bus_if.rreq, bus_if.raddr);
    end
    step();                                   // T+6
    bus_if.rack = 1; bus_if.rdata = 32'hB2;
    step();                                   // T+7
    bus_if.rack = 0;
    n_tests++;
    if ({m0_if.rack, m1_if.rack, m1_if.rdata, m0_if.rdata} !== {2'b01, 32'hB2, 32'hA1}) begin
      n_fail++; $display("FAIL rr_m1_ack: got m0r/m1r=%b m1rd=%h m0rd=%h, expected 01 B2 A1",
        {m0_if.rack, m1_if.rack}, m1_if.rdata, m0_if.rdata);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    m1_if.rreq = 1; m1_if.raddr = 32'h60;
    step();                                   // T+1
    m1_if.rreq = 0;
    step(); step();                           // T+3
    bus_if.wack = 1;                          // wrong-type ack, must be ignored
    step();                                   // T+4
    bus_if.wack = 0;
    repeat (3) step();                        // T+7
    n_tests++;
    if ({m1_if.rack, m1_if.wack, tout_pulse} !== 3'b000) begin
      n_fail++; $display("FAIL to_early: got rack/wack/tp=%b, expected 000", {m1_if.rack, m1_if.wack, tout_pulse});
    end
    step();                                   // T+8
    n_tests++;
    if ({m1_if.rack, m1_if.rdata, tout_pulse, tout_cnt} !== {1'b1, TOUT_RD, 1'b1, 16'd1}) begin
      n_fail++; $display("FAIL to_done: got rack=%b rd=%h tp=%b cnt=%0d, expected 1 DEADBEEF 1 1",
        m1_if.rack, m1_if.rdata, tout_pulse, tout_cnt);
    end
    step();                                   // T+9
    n_tests++;
    if (tout_pulse !== 1'b0) begin n_fail++; $display("FAIL to_pulse_len: got %b, expected 0", tout_pulse); end
    bus_if.rack = 1; bus_if.rdata = 32'h1234;
    step();                                   // T+10
    bus_if.rack = 0;
    n_tests++;
    if ({m0_if.rack, m1_if.rack, m1_if.rdata} !== {2'b00, TOUT_RD}) begin
      n_fail++; $display("FAIL to_stray: got racks=%b m1rd=%h, expected 00 DEADBEEF", {m0_if.rack, m1_if.rack}, m1_if.rdata);
    end
  endtask

  task automatic test_wr_before_rd();
    do_reset();
    m0_if.wreq = 1; m0_if.waddr = 32'h40; m0_if.wdata = 32'h77;
    m0_if.rreq = 1; m0_if.raddr = 32'h44;
    step();                                   // T+1: second write into a full slot
    m0_if.rreq = 0; m0_if.waddr = 32'h48; m0_if.wdata = 32'h99;
    n_tests++;
    if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b, expected 0", ovf_flag); end
    step();                                   // T+2
    m0_if.wreq = 0;
    n_tests++;
    if ({bus_if.wreq, bus_if.rreq, bus_if.waddr, bus_if.wdata, ovf_flag} !== {2'b10, 32'h40, 32'h77, 1'b1}) begin
      n_fail++; $display("FAIL wfirst_issue: got req=%b a=%h d=%h ovf=%b, expected 10 40 77 1",
        {bus_if.wreq, bus_if.rreq}, bus_if.waddr, bus_if.wdata, ovf_flag);
    end
    step();                                   // T+3
    bus_if.wack = 1;
    step();                                   // T+4
    bus_if.wack = 0;
    n_tests++;
    if (m0_if.wack !== 1'b1) begin n_fail++; $display("FAIL wfirst_wack: got %b, expected 1", m0_if.wack); end
    step();                                   // T+5
    n_tests++;
    if ({bus_if.rreq, bus_if.raddr} !== {1'b1, 32'h44}) begin
      n_fail++; $display("FAIL wfirst_read: got rreq=%b a=%h, expected 1 44", bus_if.rreq, bus_if.raddr);
    end
    bus_if.rack = 1; bus_if.rdata = 32'hCC;
    step();                                   // T+6
    bus_if.rack = 0;
    n_tests++;
    if ({m0_if.rack, m0_if.rdata} !== {1'b1, 32'hCC}) begin
      n_fail++; $display("FAIL wfirst_rack: got rack=%b rd=%h, expected 1 CC", m0_if.rack, m0_if.rdata);
    end
    repeat (3) begin
      step();
      n_tests++;
      if ({bus_if.wreq, bus_if.rreq, ovf_flag} !== 3'b001) begin
        n_fail++; $display("FAIL dropped_stays: got wreq/rreq/ovf=%b, expected 001", {bus_if.wreq, bus_if.rreq, ovf_flag});
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_if.wreq = 1; m0_if.waddr = 32'h70; m0_if.wdata = 32'h71;
    step();                                   // T+1: overflow to make ovf_flag nonzero
    step();                                   // T+2
    m0_if.wreq = 0;
    step();                                   // T+3: in WAIT
    #2 lb_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus_if.wreq, bus_if.waddr, bus_if.wdata, ovf_flag, tout_cnt, m0_if.wack, m0_if.rdata} !== '0) begin
      n_fail++; $display("FAIL rstmid_clear: got wreq=%b a=%h d=%h ovf=%b cnt=%0d wack=%b rd=%h, expected all 0",
        bus_if.wreq, bus_if.waddr, bus_if.wdata, ovf_flag, tout_cnt, m0_if.wack, m0_if.rdata);
    end
    step();
    lb_rst_n = 1'b1;
    step();
    bus_if.wack = 1;                          // late ack from the abandoned transfer
    step();
    bus_if.wack = 0;
    repeat (3) begin
      n_tests++;
      if ({m0_if.wack, m1_if.wack, m0_if.rack, m1_if.rack, bus_if.wreq} !== 5'b0) begin
        n_fail++; $display("FAIL rstmid_late_ack: got acks/wreq=%b, expected 00000",
          {m0_if.wack, m1_if.wack, m0_if.rack, m1_if.rack, bus_if.wreq});
      end
      step();
    end
  endtask

  task automatic test_ack_at_timeout();
    do_reset();
    m0_if.rreq = 1; m0_if.raddr = 32'h50;
    step();                                   // T+1
    m0_if.rreq = 0;
    repeat (6) step();                        // T+7: counter equals the limit
    bus_if.rack = 1; bus_if.rdata = 32'h5A5A;
    step();                                   // T+8
    bus_if.rack = 0;
    n_tests++;
    if ({m0_if.rack, m0_if.rdata, tout_pulse, tout_cnt} !== {1'b1, 32'h5A5A, 1'b0, 16'd0}) begin
      n_fail++; $display("FAIL ack_wins: got rack=%b rd=%h tp=%b cnt=%0d, expected 1 5A5A 0 0",
        m0_if.rack, m0_if.rdata, tout_pulse, tout_cnt);
    end
    step();
    n_tests++;
    if ({tout_pulse, m0_if.rack} !== 2'b00) begin
      n_fail++; $display("FAIL ack_wins_after: got tp/rack=%b, expected 00", {tout_pulse, m0_if.rack});
    end
  endtask

  // Transaction-level model: slots per (master, kind), one transfer in flight whose age counts cycles
  // since issue; it completes on the matching ack or after TOUT+1 waiting cycles.
  task automatic test_random();
    logic        sv [2][2];
    logic [31:0] sa [2][2];
    logic [31:0] sd [2];
    logic        i_req [2][2];
    logic [31:0] i_addr [2][2];
    logic [31:0] i_wd [2];
    logic        i_wack, i_rack, acc, tmo, done;
    logic [31:0] i_rdata;
    logic        fr [2][2];
    logic [3:0]  e_ack;
    logic [31:0] e_rd [2];
    logic [31:0] e_waddr, e_raddr, e_wdata;
    logic        e_tp, e_ovf, p0, p1;
    int          age, cm, ct, ptr, g, e_tc;
    do_reset();
    for (int m = 0; m < 2; m++) begin
      for (int t = 0; t < 2; t++) begin sv[m][t] = 0; sa[m][t] = '0; end
      sd[m] = '0; e_rd[m] = '0;
    end
    age = -1; cm = 0; ct = 0; ptr = 0; e_tc = 0; e_ovf = 0; e_tp = 0;
    e_waddr = '0; e_raddr = '0; e_wdata = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int m = 0; m < 2; m++) begin
        for (int t = 0; t < 2; t++) begin
          i_req[m][t]  = ($urandom_range(0, 5) == 0);
          i_addr[m][t] = $urandom;
        end
        i_wd[m] = $urandom;
      end
      i_wack = ($urandom_range(0, 3) == 0);
      i_rack = ($urandom_range(0, 3) == 0);
      i_rdata = $urandom;
      m0_if.wreq = i_req[0][0]; m0_if.waddr = i_addr[0][0]; m0_if.wdata = i_wd[0];
      m0_if.rreq = i_req[0][1]; m0_if.raddr = i_addr[0][1];
      m1_if.wreq = i_req[1][0]; m1_if.waddr = i_addr[1][0]; m1_if.wdata = i_wd[1];
      m1_if.rreq = i_req[1][1]; m1_if.raddr = i_addr[1][1];
      bus_if.wack = i_wack; bus_if.rack = i_rack; bus_if.rdata = i_rdata;

      acc  = (age >= 0) && ((ct == 0) ? i_wack : i_rack);
      tmo  = !acc && (age >= 1) && ((age - 1) == TOUT);
      done = acc || tmo;
      for (int m = 0; m < 2; m++)
        for (int t = 0; t < 2; t++) fr[m][t] = done && (cm == m) && (ct == t);
      e_ack = '0;
      if (done) begin
        e_ack[cm * 2 + ct] = 1'b1;
        if (ct == 1) e_rd[cm] = acc ? i_rdata : TOUT_RD;
      end
      e_tp = tmo;
      if (tmo && e_tc < 65535) e_tc++;
      p0 = sv[0][0] || sv[0][1];
      p1 = sv[1][0] || sv[1][1];
      if (age < 0) begin
        if (p0 || p1) begin
          g  = (p0 && p1) ? ptr : (p1 ? 1 : 0);
          cm = g; ct = sv[g][0] ? 0 : 1; ptr = 1 - g; age = 0;
          if (ct == 0) begin e_waddr = sa[g][0]; e_wdata = sd[g]; end
          else e_raddr = sa[g][1];
        end
      end else if (done) age = -1;
      else age++;
      for (int m = 0; m < 2; m++)
        for (int t = 0; t < 2; t++) begin
          if (i_req[m][t]) begin
            if (sv[m][t] && !fr[m][t]) e_ovf = 1;
            else begin
              sv[m][t] = 1; sa[m][t] = i_addr[m][t];
              if (t == 0) sd[m] = i_wd[m];
            end
          end else if (fr[m][t]) sv[m][t] = 0;
        end

      step();
      n_tests++;
      if ({m1_if.rack, m1_if.wack, m0_if.rack, m0_if.wack} !== e_ack) begin
        n_fail++; $display("FAIL rnd_acks c=%0d: got %b, expected %b", c,
          {m1_if.rack, m1_if.wack, m0_if.rack, m0_if.wack}, e_ack);
      end
      n_tests++;
      if ({m0_if.rdata, m1_if.rdata} !== {e_rd[0], e_rd[1]}) begin
        n_fail++; $display("FAIL rnd_rdata c=%0d: got %h %h, expected %h %h", c, m0_if.rdata, m1_if.rdata, e_rd[0], e_rd[1]);
      end
      n_tests++;
      if ({bus_if.wreq, bus_if.rreq} !== {(age == 0 && ct == 0), (age == 0 && ct == 1)}) begin
        n_fail++; $display("FAIL rnd_busreq c=%0d: got %b, expected %b", c, {bus_if.wreq, bus_if.rreq},
          {(age == 0 && ct == 0), (age == 0 && ct == 1)});
      end
      n_tests++;
      if ({bus_if.waddr, bus_if.wdata, bus_if.raddr} !== {e_waddr, e_wdata, e_raddr}) begin
        n_fail++; $display("FAIL rnd_busaddr c=%0d: got %h %h %h, expected %h %h %h", c,
          bus_if.waddr, bus_if.wdata, bus_if.raddr, e_waddr, e_wdata, e_raddr);
      end
      n_tests++;
      if ({tout_pulse, tout_cnt, ovf_flag} !== {e_tp, 16'(e_tc), e_ovf}) begin
        n_fail++; $display("FAIL rnd_status c=%0d: got tp=%b cnt=%0d ovf=%b, expected tp=%b cnt=%0d ovf=%b", c,
          tout_pulse, tout_cnt, ovf_flag, e_tp, e_tc, e_ovf);
      end
    end
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_timeout();
    test_wr_before_rd();
    test_reset_mid();
    test_ack_at_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
